// File: rtl/rob_commit_if.sv
// Commit-stage bundle: ROB head entries and store-buffer status in, and
// retirement acks, rename map / free-list updates and flush/redirect out.
interface rob_commit_if #(
   parameter int unsigned ARCH_W = 5,
   parameter int unsigned PREG_W = 6,
   parameter int unsigned PC_W   = 32
);
   logic [1:0]          head_valid;
   logic [2*ARCH_W-1:0] head_arch_dst;
   logic [2*PREG_W-1:0] head_phy_dst;
   logic [2*PREG_W-1:0] head_old_phy;
   logic [1:0]          head_wb;
   logic [1:0]          head_store;
   logic [1:0]          head_exc;
   logic [1:0]          head_mispred;
   logic [2*PC_W-1:0]   head_target;
   logic [2*PC_W-1:0]   head_pc;
   logic                sb_ready;

   logic [1:0]          commit_ack;
   logic [1:0]          rat_we;
   logic [2*ARCH_W-1:0] rat_arch;
   logic [2*PREG_W-1:0] rat_phy;
   logic [1:0]          fl_free_valid;
   logic [2*PREG_W-1:0] fl_free_phy;
   logic                sb_commit;
   logic                flush;
   logic [PC_W-1:0]     redirect_pc;
   logic [PC_W-1:0]     exc_pc;
   logic [31:0]         retired_cnt;

   modport master (
      output head_valid, head_arch_dst, head_phy_dst, head_old_phy, head_wb, head_store,
             head_exc, head_mispred, head_target, head_pc, sb_ready,
      input  commit_ack, rat_we, rat_arch, rat_phy, fl_free_valid, fl_free_phy, sb_commit,
             flush, redirect_pc, exc_pc, retired_cnt
   );

   modport slave (
      input  head_valid, head_arch_dst, head_phy_dst, head_old_phy, head_wb, head_store,
             head_exc, head_mispred, head_target, head_pc, sb_ready,
      output commit_ack, rat_we, rat_arch, rat_phy, fl_free_valid, fl_free_phy, sb_commit,
             flush, redirect_pc, exc_pc, retired_cnt
   );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order two-wide retirement stage: acks the ROB head, updates the rename map and
// free list, and on exception/mispredict raises a flush followed by a drain window.
module rob_commit_unit #(
   parameter int unsigned     ARCH_W       = 5,
   parameter int unsigned     PREG_W       = 6,
   parameter int unsigned     PC_W         = 32,
   parameter logic [PC_W-1:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int unsigned     FLUSH_CYCLES = 2
) (
   input logic         clk,
   input logic         rst,
   rob_commit_if.slave bus
);
   localparam logic [1:0] StRun   = 2'd0;
   localparam logic [1:0] StFlush = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam int unsigned DrainW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   logic [1:0]          state_q, state_d;
   logic [DrainW-1:0]   drain_q, drain_d;
   logic [1:0]          ack;
   logic                cause;
   logic [1:0]          rat_we_q, rat_we_d;
   logic [2*ARCH_W-1:0] rat_arch_q, rat_arch_d;
   logic [2*PREG_W-1:0] rat_phy_q, rat_phy_d;
   logic [1:0]          fl_valid_q, fl_valid_d;
   logic [2*PREG_W-1:0] fl_phy_q, fl_phy_d;
   logic                sb_commit_q, sb_commit_d;
   logic                flush_q;
   logic [PC_W-1:0]     redirect_q, redirect_d;
   logic [PC_W-1:0]     exc_pc_q, exc_pc_d;
   logic [31:0]         cnt_q, cnt_d;

   // Slot 1 never carries a flush cause; it waits until it becomes slot 0.
   always_comb begin
      ack = 2'b00;
      if (rst && state_q == StRun) begin
         ack[0] = bus.head_valid[0] && !(bus.head_store[0] && !bus.sb_ready);
         ack[1] = ack[0] && bus.head_valid[1] &&
                  !bus.head_exc[0] && !bus.head_mispred[0] &&
                  !bus.head_exc[1] && !bus.head_mispred[1] &&
                  !(bus.head_store[1] && (bus.head_store[0] || !bus.sb_ready));
      end
   end

   assign cause = ack[0] && (bus.head_exc[0] || bus.head_mispred[0]);

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      unique case (state_q)
         StRun:   if (cause) state_d = StFlush;
         StFlush: begin
            state_d = StDrain;
            drain_d = DrainW'(FLUSH_CYCLES - 1);
         end
         StDrain: begin
            if (drain_q == '0) state_d = StRun;
            else               drain_d = drain_q - DrainW'(1);
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      rat_we_d    = '0;
      rat_arch_d  = '0;
      rat_phy_d   = '0;
      fl_valid_d  = '0;
      fl_phy_d    = '0;
      sb_commit_d = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (ack[i] && !bus.head_exc[i]) begin
            if (bus.head_wb[i]) begin
               rat_we_d[i]                  = 1'b1;
               rat_arch_d[i*ARCH_W +: ARCH_W] = bus.head_arch_dst[i*ARCH_W +: ARCH_W];
               rat_phy_d[i*PREG_W +: PREG_W]  = bus.head_phy_dst[i*PREG_W +: PREG_W];
               fl_valid_d[i]                = 1'b1;
               fl_phy_d[i*PREG_W +: PREG_W]   = bus.head_old_phy[i*PREG_W +: PREG_W];
            end
            if (bus.head_store[i]) sb_commit_d = 1'b1;
         end
      end
      redirect_d = '0;
      exc_pc_d   = '0;
      if (cause) begin
         redirect_d = bus.head_exc[0] ? EXC_VECTOR : bus.head_target[PC_W-1:0];
         if (bus.head_exc[0]) exc_pc_d = bus.head_pc[PC_W-1:0];
      end
      cnt_d = cnt_q + 32'(ack[0]) + 32'(ack[1]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StRun;
         drain_q     <= '0;
         rat_we_q    <= '0;
         rat_arch_q  <= '0;
         rat_phy_q   <= '0;
         fl_valid_q  <= '0;
         fl_phy_q    <= '0;
         sb_commit_q <= 1'b0;
         flush_q     <= 1'b0;
         redirect_q  <= '0;
         exc_pc_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         rat_we_q    <= rat_we_d;
         rat_arch_q  <= rat_arch_d;
         rat_phy_q   <= rat_phy_d;
         fl_valid_q  <= fl_valid_d;
         fl_phy_q    <= fl_phy_d;
         sb_commit_q <= sb_commit_d;
         flush_q     <= cause;
         redirect_q  <= redirect_d;
         exc_pc_q    <= exc_pc_d;
         cnt_q       <= cnt_d;
      end
   end

   logic unused_slot1;
   assign unused_slot1 = ^{bus.head_target[2*PC_W-1:PC_W], bus.head_pc[2*PC_W-1:PC_W]};

   assign bus.commit_ack    = ack;
   assign bus.rat_we        = rat_we_q;
   assign bus.rat_arch      = rat_arch_q;
   assign bus.rat_phy       = rat_phy_q;
   assign bus.fl_free_valid = fl_valid_q;
   assign bus.fl_free_phy   = fl_phy_q;
   assign bus.sb_commit     = sb_commit_q;
   assign bus.flush         = flush_q;
   assign bus.redirect_pc   = redirect_q;
   assign bus.exc_pc        = exc_pc_q;
   assign bus.retired_cnt   = cnt_q;
endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: directed cases, then random ROB-head traffic
// checked against a queue-driven reference model.
module tb_rob_commit_unit;
   localparam int unsigned FLUSH_CYCLES = 2;
   localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;

   typedef struct packed {
      bit        rst;
      bit [1:0]  v, wb, st, exc, mp;
      bit [9:0]  arch;
      bit [11:0] phy, old;
      bit [63:0] tgt, pc;
      bit        sb_ready;
   } stim_t;

   typedef struct packed {
      logic [1:0]  ack, rat_we;
      logic [9:0]  rat_arch;
      logic [11:0] rat_phy;
      logic [1:0]  fl_v;
      logic [11:0] fl_phy;
      logic        sb, flush;
      logic [31:0] redirect, exc_pc, cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rob_commit_if #(.ARCH_W(5), .PREG_W(6), .PC_W(32)) bus ();

   rob_commit_unit #(
      .ARCH_W(5), .PREG_W(6), .PC_W(32), .EXC_VECTOR(EXC_VECTOR), .FLUSH_CYCLES(FLUSH_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t ack_q[$];
   exp_t reg_q[$];

   // Reference model state: cycles left with commit blocked, and the retire count.
   int          hold  = 0;
   logic [31:0] cnt_m = '0;

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic stim_t idle();
      stim_t s = '0;
      s.rst      = 1'b1;
      s.sb_ready = 1'b1;
      return s;
   endfunction

   task automatic step(input stim_t s);
      exp_t     e = '0;
      logic [1:0] a = 2'b00;
      bit       stores = 1'b0;
      @(negedge clk);
      rst                = s.rst;
      bus.head_valid     = s.v;
      bus.head_arch_dst  = s.arch;
      bus.head_phy_dst   = s.phy;
      bus.head_old_phy   = s.old;
      bus.head_wb        = s.wb;
      bus.head_store     = s.st;
      bus.head_exc       = s.exc;
      bus.head_mispred   = s.mp;
      bus.head_target    = s.tgt;
      bus.head_pc        = s.pc;
      bus.sb_ready       = s.sb_ready;
      if (!s.rst) begin
         hold  = 0;
         cnt_m = '0;
      end else begin
         if (hold > 0) hold--;
         else begin
            // Walk oldest first; stop at the first entry that cannot retire now.
            for (int i = 0; i < 2; i++) begin
               if (!s.v[i]) break;
               if (s.st[i] && (!s.sb_ready || stores)) break;
               if (i == 1 && (s.exc[i] || s.mp[i])) break;
               a[i] = 1'b1;
               stores |= s.st[i];
               if (s.exc[i] || s.mp[i]) break;
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (a[i] && !s.exc[i] && s.wb[i]) begin
               e.rat_we[i]            = 1'b1;
               e.rat_arch[i*5 +: 5]   = s.arch[i*5 +: 5];
               e.rat_phy[i*6 +: 6]    = s.phy[i*6 +: 6];
               e.fl_v[i]              = 1'b1;
               e.fl_phy[i*6 +: 6]     = s.old[i*6 +: 6];
            end
            if (a[i] && !s.exc[i] && s.st[i]) e.sb = 1'b1;
            if (a[i] && (s.exc[i] || s.mp[i])) begin
               e.flush    = 1'b1;
               e.redirect = s.exc[i] ? EXC_VECTOR : s.tgt[i*32 +: 32];
               e.exc_pc   = s.exc[i] ? s.pc[i*32 +: 32] : 32'h0;
               hold       = 1 + FLUSH_CYCLES;
            end
         end
         cnt_m = cnt_m + 32'(a[0]) + 32'(a[1]);
      end
      e.ack = a;
      e.cnt = cnt_m;
      ack_q.push_back(e);
      reg_q.push_back(e);
   endtask

   // Combinational ack, sampled after inputs settle.
   initial forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (ack_q.size() > 0) begin
         e = ack_q.pop_front();
         check("commit_ack", 128'(bus.commit_ack), 128'(e.ack));
      end
   end

   // Registered outputs, sampled just after the edge that produced them.
   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
         e = reg_q.pop_front();
         check("rat", 128'({bus.rat_we, bus.rat_arch, bus.rat_phy}),
               128'({e.rat_we, e.rat_arch, e.rat_phy}));
         check("free_list", 128'({bus.fl_free_valid, bus.fl_free_phy}), 128'({e.fl_v, e.fl_phy}));
         check("sb_flush", 128'({bus.sb_commit, bus.flush}), 128'({e.sb, e.flush}));
         check("redirect", 128'({bus.redirect_pc, bus.exc_pc}), 128'({e.redirect, e.exc_pc}));
         check("retired_cnt", 128'(bus.retired_cnt), 128'(e.cnt));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      stim_t s;
      s = idle(); s.rst = 1'b0;
      step(s); step(s);

      // Two plain ALU uops.
      s = idle(); s.v = 2'b11; s.wb = 2'b11;
      s.arch = {5'd5, 5'd3}; s.phy = {6'd11, 6'd10}; s.old = {6'd6, 6'd4};
      step(s);
      step(idle());

      // Slot 0 mispredicted link write, then a blocked window despite valid heads.
      s = idle(); s.v = 2'b11; s.wb = 2'b01; s.mp = 2'b01; s.arch = {5'd1, 5'd31};
      s.phy = {6'd2, 6'd20}; s.old = {6'd3, 6'd21}; s.tgt = {32'h0, 32'h8000_1000};
      step(s);
      s.mp = 2'b00;
      step(s); step(s); step(s); step(s);

      // Faulting uop in slot 1 waits to become slot 0.
      s = idle(); s.v = 2'b11; s.wb = 2'b11; s.exc = 2'b10; s.arch = {5'd7, 5'd8};
      s.phy = {6'd30, 6'd31}; s.old = {6'd12, 6'd13}; s.pc = {32'h0000_2004, 32'h0000_2000};
      step(s);
      s = idle(); s.v = 2'b01; s.wb = 2'b01; s.exc = 2'b01; s.arch = {5'd0, 5'd7};
      s.phy = {6'd0, 6'd30}; s.old = {6'd0, 6'd12}; s.pc = {32'h0, 32'h0000_2004};
      step(s);
      repeat (4) step(idle());

      // Two stores: one per cycle, none without store-buffer space.
      s = idle(); s.v = 2'b11; s.st = 2'b11;
      step(s);
      s.sb_ready = 1'b0;
      step(s);

      // Same arch register in both slots; both releases visible.
      s = idle(); s.v = 2'b11; s.wb = 2'b11; s.arch = {5'd9, 5'd9};
      s.phy = {6'd40, 6'd41}; s.old = {6'd42, 6'd43};
      step(s);

      // Reset in the drain window abandons the flush.
      s = idle(); s.v = 2'b01; s.mp = 2'b01; s.tgt = {32'h0, 32'h1234_5678};
      step(s);
      step(idle());
      s = idle(); s.rst = 1'b0;
      step(s);
      s = idle(); s.v = 2'b11; s.wb = 2'b11; s.arch = {5'd2, 5'd4};
      s.phy = {6'd50, 6'd51}; s.old = {6'd52, 6'd53};
      step(s);
      step(idle());

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         s          = idle();
         s.rst      = ($urandom_range(0, 63) != 0);
         s.v        = 2'($urandom_range(0, 3));
         s.wb       = 2'($urandom_range(0, 3));
         s.st       = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         s.exc      = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
         s.mp       = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
         s.arch     = 10'($urandom);
         s.phy      = 12'($urandom);
         s.old      = 12'($urandom);
         s.tgt      = {$urandom, $urandom};
         s.pc       = {$urandom, $urandom};
         s.sb_ready = ($urandom_range(0, 3) != 0);
         step(s);
      end
      repeat (4) step(idle());

      // Counter wrap: preload 2^32-1 retires, then retire two more.
      step(idle());
      @(posedge clk);
      #2;
      force dut.cnt_q = 32'hFFFF_FFFF;
      cnt_m = 32'hFFFF_FFFF;
      step(idle());
      @(posedge clk);
      #2;
      release dut.cnt_q;
      s = idle(); s.v = 2'b11;
      step(s);
      step(idle());

      @(posedge clk);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- In-order retirement stage directly downstream of the ROB.
- Each cycle it inspects the two oldest ROB entries and acknowledges the ones that may retire, up to 2 per cycle.
- For retired entries it releases old physical registers to the free list and updates the architectural rename map.
- On a branch mispredict or exception it raises a pipeline flush with a redirect PC, then holds off commit for a fixed drain window.

Parameters:
- ARCH_W, 5, architectural register index width
- PREG_W, 6, physical register index width
- PC_W, 32, program counter width
- EXC_VECTOR, 32'hBFC00380, redirect PC on exception
- FLUSH_CYCLES, 2, commit-blocked cycles after a flush pulse (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- head_valid  in  2  [0]=oldest ROB entry valid and finished, [1]=next-oldest entry valid and finished
- head_arch_dst  in  2*ARCH_W  architectural destination per slot
- head_phy_dst  in  2*PREG_W  new physical destination per slot
- head_old_phy  in  2*PREG_W  previous physical mapping per slot
- head_wb  in  2  slot writes a register
- head_store  in  2  slot is a store
- head_exc  in  2  slot raised an exception
- head_mispred  in  2  slot is a mispredicted branch
- head_target  in  2*PC_W  correct branch target per slot
- head_pc  in  2*PC_W  PC per slot
- sb_ready  in  1  store buffer can accept a store commit this cycle
- commit_ack  out  2  combinational; ROB pops the acknowledged slots this cycle
- rat_we  out  2  architectural RAT write enable (registered)
- rat_arch  out  2*ARCH_W  RAT write index
- rat_phy  out  2*PREG_W  RAT write data
- fl_free_valid  out  2  free-list release valid (registered)
- fl_free_phy  out  2*PREG_W  physical register released
- sb_commit  out  1  store buffer retire pulse (registered)
- flush  out  1  one-cycle pipeline flush pulse (registered)
- redirect_pc  out  PC_W  valid while flush=1
- exc_pc  out  PC_W  PC of the excepting uop, valid while flush=1 due to an exception
- retired_cnt  out  32  total retired uops, wraps modulo 2^32

Behaviour:
- Reset (rst=0 at posedge): all outputs 0, state RUN, counter 0; reset mid-flush abandons the flush (no further flush pulse).
- States:
  - RUN: acks are computed from the rules below; a flush cause goes to FLUSH after the edge.
  - FLUSH: flush=1 for exactly one cycle, commit_ack=0; then DRAIN.
  - DRAIN: commit_ack=0 for FLUSH_CYCLES cycles, counted from the cycle after the flush pulse; then RUN.
- Slot 0 ack: head_valid[0] && !(head_store[0] && !sb_ready).
- Slot 1 ack: requires all of
  - slot 0 acked;
  - head_valid[1];
  - head_exc[0]=0 and head_mispred[0]=0;
  - head_exc[1]=0 and head_mispred[1]=0 (a faulting slot 1 waits to become slot 0);
  - not (head_store[1] && (head_store[0] || !sb_ready)), i.e. at most one store per cycle.
- Acked slot with exc=1:
  - no RAT write, no free-list release, no sb_commit;
  - counts as retired;
  - flush with redirect_pc=EXC_VECTOR and exc_pc=head_pc.
- Acked slot with mispred=1 (and exc=0):
  - normal retirement, including a link-register write if wb=1;
  - flush with redirect_pc=head_target.
  - exc takes priority over mispred.
- Acked slot with wb=1 and no exc:
  - rat_we=1, rat_arch=arch_dst, rat_phy=phy_dst;
  - fl_free_valid=1, fl_free_phy=old_phy;
  - all registered, asserted in the cycle after the ack.
- Both slots writing the same arch register:
  - both RAT ports asserted; port 1 has priority in the RAT;
  - both old_phy values are released.
- Acked store: sb_commit=1 next cycle.
- retired_cnt += popcount(commit_ack) each cycle.
- head_valid=0 on slot 0 → ack 0 on both slots (no out-of-order retire).

Test Plan:
- Two plain ALU uops:
  - slot0 {arch 3, phy 10, old 4}, slot1 {arch 5, phy 11, old 6}, both wb → ack=2'b11;
  - next cycle rat_we=11, rat_phy={11,10}, fl_free_phy={6,4}, retired_cnt=2.
- Slot0 mispred, target 0x80001000, wb=1 (arch 31):
  - ack=01, rat_we[0]=1;
  - flush=1, redirect_pc=0x80001000 next cycle;
  - ack=0 for 1+FLUSH_CYCLES=3 cycles, even with head_valid=11.
- Slot1 exception, slot0 plain:
  - ack=01, no flush;
  - next cycle the faulting uop in slot0 → ack=01, no RAT/free-list writes;
  - flush=1 with redirect_pc=0xBFC00380 and exc_pc equal to its PC.
- Two stores, sb_ready=1 → ack=01, sb_commit=1; sb_ready=0 → ack=00.
- Reset asserted during DRAIN → all outputs 0; the next valid pair is acked in the first cycle after release.
- 2^32 - 1 retires then 2 more → retired_cnt wraps to 1.
